regbank_read_ctrl: RTL
======================

REGBANK_READ_CTRL -- requirements
Module: regbank_read_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 8: number of implemented registers, 1..2^AW.
REQ-003 The block SHALL have parameter AW, default 3: address width.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 wr_en  in  1  write strobe.
REQ-007 wr_addr  in  AW  write register index.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 wr_mask  in  WIDTH  per-bit write enable; 1 = bit updated.
REQ-010 rd_req_valid  in  1  read request present.
REQ-011 rd_req_ready  out  1  block can accept a read request.
REQ-012 rd_addr  in  AW  read register index, qualified by rd_req_valid.
REQ-013 rd_rsp_valid  out  1  response data valid.
REQ-014 rd_rsp_ready  in  1  consumer accepts the response.
REQ-015 rd_rsp_data  out  WIDTH  response data.
REQ-016 rd_rsp_err  out  1  response addressed a register >= NREGS.

Function
REQ-017 Write: on posedge clk with wr_en=1 and wr_addr<NREGS, bits of reg[wr_addr] with wr_mask=1 SHALL take wr_data, other bits hold; wr_addr>=NREGS SHALL be ignored.
REQ-018 A read request SHALL be accepted on a posedge clk where rd_req_valid=1 and rd_req_ready=1.
REQ-019 rd_req_ready SHALL equal (!rd_rsp_valid || rd_rsp_ready), combinationally, and SHALL be 0 during reset.
REQ-020 Response state machine SHALL have two states: EMPTY (rd_rsp_valid=0) and FULL (rd_rsp_valid=1).
REQ-021 EMPTY->FULL on accept; FULL->EMPTY on rd_rsp_ready=1 with no accept; FULL->FULL with reloaded data when rd_rsp_ready=1 and accept occur in the same cycle.
REQ-022 Latency SHALL be 1 cycle: rd_rsp_valid asserts on the edge that accepts the request; sustained throughput SHALL be one read per cycle.
REQ-023 rd_rsp_data SHALL be the content of reg[rd_addr] as it was before the accepting edge (subject to REQ-033).
REQ-024 While rd_rsp_valid=1 and rd_rsp_ready=0, rd_rsp_data and rd_rsp_err SHALL hold stable and no request is accepted.
REQ-025 rd_addr>=NREGS SHALL produce rd_rsp_data=0 and rd_rsp_err=1; otherwise rd_rsp_err=0.
REQ-026 Writes SHALL proceed every cycle, independent of read stalls.
REQ-027 rd_rsp_ready while EMPTY SHALL have no effect.

Reset
REQ-028 reset=1 SHALL, unconditionally and regardless of wr_en/wr_mask, clear all registers to 0.
REQ-029 reset=1 SHALL drive the state to EMPTY: rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0.
REQ-030 A pending response SHALL be discarded by a mid-operation reset; requests presented during reset SHALL NOT be accepted.
REQ-031 A write presented in the same cycle as reset SHALL be dropped.

Configuration
REQ-032 Macro REGBANK_RD_BYPASS_EN SHALL select write-to-read bypass.
REQ-033 With REGBANK_RD_BYPASS_EN defined, a read accepted in the same cycle as a write to the same in-range address SHALL return the merged value ((old & ~wr_mask) | (wr_data & wr_mask)).
REQ-034 Without REGBANK_RD_BYPASS_EN, the same case SHALL return the old value; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then read reg 3 with rd_rsp_ready=1 -> rd_rsp_valid one cycle later, data 0x0000, err 0.
REQ-036 Write reg 2 = 0xABCD with mask 0xFFFF, then mask 0x00FF with data 0x1234 -> read reg 2 returns 0xAB34.
REQ-037 Back-to-back reads of regs 0..7 with rd_rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order.
REQ-038 Hold rd_rsp_ready=0 for 3 cycles with a response pending -> rd_req_ready=0 and data stable; release -> next request accepted in the same cycle.
REQ-039 Read reg 5=0x0F0F concurrently with write 0xFFFF, mask 0xFFFF -> 0xFFFF with REGBANK_RD_BYPASS_EN, 0x0F0F without; with NREGS=6 read addr 7 -> data 0, err 1.
REQ-040 Assert reset while FULL -> next cycle rd_rsp_valid=0 and all registers read back 0.

Source files
------------

// File: rtl/regbank_read_ctrl.sv
// Register bank with masked writes and a one-deep, fully pipelined read
// response stage (valid/ready handshake on both request and response).
// Optional feature: define REGBANK_RD_BYPASS_EN to forward a same-cycle
// write into a read of the same register (merged old/new value).
module regbank_read_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_rsp_valid,
  input  logic             rd_rsp_ready,
  output logic [WIDTH-1:0] rd_rsp_data,
  output logic             rd_rsp_err
);

  // One extra bit so NREGS == 2**AW still compares correctly.
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [NREGS-1:0] w_wr_sel;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_rd_in_range;
  logic [WIDTH-1:0] w_rd_old;
  logic [WIDTH-1:0] w_rd_value;

  // Per-register write decode; out-of-range write addresses select nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_wr_sel
      assign w_wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
    end
  endgenerate

  // Masked register writes; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= (r_regs[i] & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

  // A new request fits whenever the response slot is empty or being drained.
  assign w_req_ready   = !reset && ((r_state == ST_EMPTY) || rd_rsp_ready);
  assign w_accept      = rd_req_valid && w_req_ready;
  assign w_rd_in_range = ({1'b0, rd_addr} < NREGS_W);
  assign w_rd_old      = w_rd_in_range ? r_regs[rd_addr] : '0;

`ifdef REGBANK_RD_BYPASS_EN
  logic w_rd_hit;
  // Forward a write landing on the same edge so the reader sees the new value.
  assign w_rd_hit   = wr_en && (wr_addr == rd_addr) && w_rd_in_range;
  assign w_rd_value = w_rd_hit ? ((w_rd_old & ~wr_mask) | (wr_data & wr_mask))
                               : w_rd_old;
`else
  assign w_rd_value = w_rd_old;
`endif

  // Response slot FSM: load on accept, drain on consumer ready, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state    <= ST_FULL;
            r_rsp_data <= w_rd_value;
            r_rsp_err  <= !w_rd_in_range;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_state    <= ST_FULL;
            r_rsp_data <= w_rd_value;
            r_rsp_err  <= !w_rd_in_range;
          end else if (rd_rsp_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign rd_req_ready = w_req_ready;
  assign rd_rsp_valid = (r_state == ST_FULL);
  assign rd_rsp_data  = r_rsp_data;
  assign rd_rsp_err   = r_rsp_err;

endmodule
